// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Checks XOR parity and the stop level, then presents the word with error flags.
module serial_parity_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              acc;
    logic              perr;
    logic [DATA_W-1:0] shift_reg;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // term on a right-hand side is the value from before this edge and no latch can form.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            perr       <= 1'b0;
            shift_reg  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            acc     <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Shifting in at the MSB leaves the first data bit in bit 0.
                        shift_reg <= {din, shift_reg[DATA_W-1:1]};
                        acc       <= acc ^ din;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) state <= PARITY;
                    end
                    PARITY: begin
                        perr  <= acc ^ din ^ ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        // Deliver even on errors; the outputs hold until the next frame ends.
                        state      <= IDLE;
                        dout       <= shift_reg;
                        dout_valid <= 1'b1;
                        parity_err <= perr;
                        frame_err  <= ~din;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity instance share
// the same serial stimulus, and each is compared against hand-computed results.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int n_vec = 0;
    int n_bad = 0;
    int pulses_e = 0;
    int pulses_o = 0;
    logic [7:0] prev_dout = 8'h00;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .dout(dout_e), .dout_valid(dv_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .dout(dout_o), .dout_valid(dv_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    always @(posedge clk) begin
        if (dv_e === 1'b1) pulses_e++;
        if (dv_o === 1'b1) pulses_o++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         pre_gap;
        int         lead_idle;
        bit         spaced;
        logic [7:0] exp_dout;
        logic       exp_perr_e;
        logic       exp_perr_o;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        din_valid = 1'b1;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b1;
    endtask

    task automatic run_frame(input vec_t v);
        if (v.lead_idle > 0) begin
            repeat (v.lead_idle) strobe(1'b1);
            check("idle_busy", busy_e, 1'b0);
            check("idle_no_pulse", dv_e, 1'b0);
        end
        idle(v.pre_gap);
        strobe(1'b0);
        check("start_busy_e", busy_e, 1'b1);
        check("start_busy_o", busy_o, 1'b1);
        check("start_dv", dv_e, 1'b0);
        check("start_dout_hold", dout_e, prev_dout);
        for (int i = 0; i < 8; i++) begin
            idle(v.spaced ? (i % 4) : 0);
            strobe(v.data[i]);
        end
        idle(v.spaced ? 2 : 0);
        strobe(v.par);
        idle(v.spaced ? 3 : 0);
        strobe(v.stop);
        check("dv_e", dv_e, 1'b1);
        check("dv_o", dv_o, 1'b1);
        check("dout_e", dout_e, v.exp_dout);
        check("dout_o", dout_o, v.exp_dout);
        check("perr_e", perr_e, v.exp_perr_e);
        check("perr_o", perr_o, v.exp_perr_o);
        check("ferr_e", ferr_e, v.exp_ferr);
        check("ferr_o", ferr_o, v.exp_ferr);
        check("end_busy", busy_e, 1'b0);
        prev_dout = v.exp_dout;
    endtask

    initial begin
        //          data   par   stop  gap lead spc  dout   pe    po    fe
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 2, 0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1, 0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 3, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 1'b0, 1'b1, 1, 0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b1;
        idle(2);
        check("rst_dout", dout_e, 8'h00);
        check("rst_dv", dv_e, 1'b0);
        check("rst_perr", perr_o, 1'b0);
        check("rst_ferr", ferr_e, 1'b0);
        check("rst_busy", busy_e, 1'b0);
        rst = 1'b0;

        // vecs[6] follows vecs[5] with no gap: its start bit lands in the pulse cycle
        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Abort a C3 frame after four data bits, then send it whole
        idle(1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_dout", dout_e, 8'h00);
        check("midrst_dv", dv_e, 1'b0);
        check("midrst_perr_e", perr_e, 1'b0);
        check("midrst_perr_o", perr_o, 1'b0);
        check("midrst_busy", busy_e, 1'b0);
        check("midrst_pulses", pulses_e, 7);
        prev_dout = 8'h00;
        idle(2);
        check("midrst_no_pulse", pulses_e, 7);
        run_frame(vecs[7]);

        idle(3);
        check("pulse_count_e", pulses_e, 8);
        check("pulse_count_o", pulses_o, 8);
        check("final_hold", dout_e, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
